// File: rtl/snake_body_engine.sv
// Snake body engine: head steering, per-step body shift, growth, wall/self collision; optional WRAP_EN wraps the border instead of killing.
// Latency: one cycle from an accepted step (or start) to updated coordinate/segment buses; all outputs registered.
// Backpressure: none; step is ignored while paused or outside RUN, and a pending grow is held until the next accepted step.
module snake_body_engine #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 24,
    parameter int START_Y  = 13,
    parameter int X_MAX    = 47,
    parameter int Y_MAX    = 25
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   step,
    input  logic                   pause,
    input  logic [1:0]             dir_req,
    input  logic                   grow,
    output logic [MAX_LEN*6-1:0]   snake_x_temp,
    output logic [MAX_LEN*6-1:0]   snake_y_temp,
    output logic [MAX_LEN-1:0]     snake_piece_is_display,
    output logic [5:0]             length,
    output logic [1:0]             heading,
    output logic                   alive,
    output logic                   hit_wall,
    output logic                   hit_self,
    output logic                   moved
);

    localparam int BW = MAX_LEN * 6;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [5:0] X_LAST   = 6'(X_MAX);
    localparam logic [5:0] Y_LAST   = 6'(Y_MAX);
    localparam logic [5:0] X_BORDER = 6'(X_MAX + 1);
    localparam logic [5:0] Y_BORDER = 6'(Y_MAX + 1);
    localparam logic [5:0] LEN_MAX  = 6'(MAX_LEN);
    localparam logic [5:0] LEN_INIT = 6'(INIT_LEN);

    // Start layout: head at START, body trailing toward -x, unused segments zeroed.
    function automatic logic [BW-1:0] init_x_bus();
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < INIT_LEN; k++) v[6*k +: 6] = 6'(START_X - k);
        return v;
    endfunction

    function automatic logic [BW-1:0] init_y_bus();
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < INIT_LEN; k++) v[6*k +: 6] = 6'(START_Y);
        return v;
    endfunction

    localparam logic [BW-1:0]      INIT_X    = init_x_bus();
    localparam logic [BW-1:0]      INIT_Y    = init_y_bus();
    localparam logic [MAX_LEN-1:0] INIT_DISP = {MAX_LEN{1'b1}} >> (MAX_LEN - INIT_LEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
    state_t state;

    logic       grow_pending;
    logic       step_ok;
    logic       grow_req;
    logic       can_grow;
    logic [5:0] self_lim;
    logic [1:0] heading_nxt;
    logic [5:0] head_x, head_y;
    logic [5:0] raw_x, raw_y;
    logic [5:0] nx, ny;
    logic       wall_hit;
    logic       self_hit;

    assign head_x   = snake_x_temp[5:0];
    assign head_y   = snake_y_temp[5:0];
    assign step_ok  = step && !pause && (state == S_RUN);
    assign grow_req = grow_pending || grow;
    assign can_grow = grow_req && (length < LEN_MAX);
    // Tail cell is only safe to enter when it actually vacates (no growth this step).
    assign self_lim = can_grow ? length : (length - 6'd1);

    // Steering and next-head position, with border handling.
    always_comb begin
        if ((dir_req[1] != heading[1]) && (dir_req[0] == heading[0]))
            heading_nxt = heading;
        else
            heading_nxt = dir_req;

        raw_x = head_x;
        raw_y = head_y;
        case (heading_nxt)
            DIR_UP:    raw_y = head_y - 6'd1;
            DIR_DOWN:  raw_y = head_y + 6'd1;
            DIR_LEFT:  raw_x = head_x - 6'd1;
            default:   raw_x = head_x + 6'd1;
        endcase

        nx = raw_x;
        ny = raw_y;
`ifdef WRAP_EN
        wall_hit = 1'b0;
        if (raw_x == 6'd0)          nx = X_LAST;
        else if (raw_x == X_BORDER) nx = 6'd1;
        if (raw_y == 6'd0)          ny = Y_LAST;
        else if (raw_y == Y_BORDER) ny = 6'd1;
`else
        wall_hit = (raw_x == 6'd0) || (raw_x == X_BORDER) ||
                   (raw_y == 6'd0) || (raw_y == Y_BORDER);
`endif
    end

    // Compare the next head against every live segment that will still be occupied.
    always_comb begin
        self_hit = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (snake_piece_is_display[k] && (6'(k) < self_lim) &&
                (snake_x_temp[6*k +: 6] == nx) && (snake_y_temp[6*k +: 6] == ny))
                self_hit = 1'b1;
        end
    end

    // Game state, body registers and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= S_IDLE;
            snake_x_temp           <= '0;
            snake_y_temp           <= '0;
            snake_piece_is_display <= '0;
            length                 <= 6'd0;
            heading                <= DIR_RIGHT;
            alive                  <= 1'b0;
            hit_wall               <= 1'b0;
            hit_self               <= 1'b0;
            moved                  <= 1'b0;
            grow_pending           <= 1'b0;
        end else begin
            moved <= 1'b0;
            if (start) begin
                state                  <= S_RUN;
                snake_x_temp           <= INIT_X;
                snake_y_temp           <= INIT_Y;
                snake_piece_is_display <= INIT_DISP;
                length                 <= LEN_INIT;
                heading                <= DIR_RIGHT;
                alive                  <= 1'b1;
                hit_wall               <= 1'b0;
                hit_self               <= 1'b0;
                grow_pending           <= 1'b0;
            end else if (step_ok) begin
                if (wall_hit || self_hit) begin
                    state        <= S_DEAD;
                    alive        <= 1'b0;
                    hit_wall     <= hit_wall | wall_hit;
                    hit_self     <= hit_self | self_hit;
                    grow_pending <= grow_req;
                end else begin
                    heading      <= heading_nxt;
                    snake_x_temp <= {snake_x_temp[BW-7:0], nx};
                    snake_y_temp <= {snake_y_temp[BW-7:0], ny};
                    moved        <= 1'b1;
                    grow_pending <= 1'b0;
                    if (can_grow) begin
                        // Live bits are always contiguous from bit 0, so shifting in a 1 sets bit[length].
                        snake_piece_is_display <= {snake_piece_is_display[MAX_LEN-2:0], 1'b1};
                        length                 <= length + 6'd1;
                    end
                end
            end else if (grow) begin
                grow_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

    localparam logic [1:0] U = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] D = 2'b10;
    localparam logic [1:0] L = 2'b11;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, step, pause, grow;
    logic [1:0]    dir_req;
    logic [191:0]  snake_x_temp, snake_y_temp;
    logic [31:0]   snake_piece_is_display;
    logic [5:0]    length;
    logic [1:0]    heading;
    logic          alive, hit_wall, hit_self, moved;

    always #5 clock = ~clock;

    snake_body_engine dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .start                  (start),
        .step                   (step),
        .pause                  (pause),
        .dir_req                (dir_req),
        .grow                   (grow),
        .snake_x_temp           (snake_x_temp),
        .snake_y_temp           (snake_y_temp),
        .snake_piece_is_display (snake_piece_is_display),
        .length                 (length),
        .heading                (heading),
        .alive                  (alive),
        .hit_wall               (hit_wall),
        .hit_self               (hit_self),
        .moved                  (moved)
    );

    typedef struct {
        string       name;
        logic [5:0]  hx, hy;
        int          si;
        logic [5:0]  sx, sy;
        logic [31:0] disp;
        logic [5:0]  len;
        logic [1:0]  hd;
        logic        al, hw, hs, mv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, expv);
        end
    endtask

    // Monitor: one expected snapshot is consumed per falling edge once the stimulus has queued it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "head_x", 32'(snake_x_temp[5:0]), 32'(e.hx));
                chk(e.name, "head_y", 32'(snake_y_temp[5:0]), 32'(e.hy));
                chk(e.name, "seg_x",  32'(snake_x_temp[6*e.si +: 6]), 32'(e.sx));
                chk(e.name, "seg_y",  32'(snake_y_temp[6*e.si +: 6]), 32'(e.sy));
                chk(e.name, "display", snake_piece_is_display, e.disp);
                chk(e.name, "length", 32'(length), 32'(e.len));
                chk(e.name, "heading", 32'(heading), 32'(e.hd));
                chk(e.name, "alive", 32'(alive), 32'(e.al));
                chk(e.name, "hit_wall", 32'(hit_wall), 32'(e.hw));
                chk(e.name, "hit_self", 32'(hit_self), 32'(e.hs));
                chk(e.name, "moved", 32'(moved), 32'(e.mv));
            end
        end
    end

    task automatic push_exp(input string nm, input int hx, input int hy, input int si,
                            input int sx, input int sy, input logic [31:0] disp, input int len,
                            input logic [1:0] hd, input logic al, input logic hw, input logic hs,
                            input logic mv);
        exp_t e;
        e.name = nm; e.hx = 6'(hx); e.hy = 6'(hy); e.si = si; e.sx = 6'(sx); e.sy = 6'(sy);
        e.disp = disp; e.len = 6'(len); e.hd = hd; e.al = al; e.hw = hw; e.hs = hs; e.mv = mv;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; inputs drop back to idle just after the sampling edge.
    task automatic op(input logic st, input logic sp, input logic pa, input logic [1:0] d, input logic gr);
        @(negedge clock);
        start = st; step = sp; pause = pa; dir_req = d; grow = gr;
        @(posedge clock);
        #1;
        start = 1'b0; step = 1'b0; pause = 1'b0; grow = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0; step = 1'b0; pause = 1'b0; grow = 1'b0; dir_req = R;
        repeat (2) @(posedge clock);
        #1;
        push_exp("reset", 0, 0, 1, 0, 0, 32'h0, 0, R, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        op(0, 1, 0, R, 0);
        push_exp("idle_step", 0, 0, 1, 0, 0, 32'h0, 0, R, 0, 0, 0, 0);

        op(1, 0, 0, R, 0);
        push_exp("start", 24, 13, 2, 22, 13, 32'h7, 3, R, 1, 0, 0, 0);

        op(0, 1, 0, L, 0);
        push_exp("reverse_ignored", 25, 13, 2, 23, 13, 32'h7, 3, R, 1, 0, 0, 1);
        op(0, 0, 0, L, 0);
        push_exp("moved_once", 25, 13, 1, 24, 13, 32'h7, 3, R, 1, 0, 0, 0);

        op(0, 1, 1, U, 0);
        push_exp("paused", 25, 13, 2, 23, 13, 32'h7, 3, R, 1, 0, 0, 0);

        op(1, 1, 0, D, 0);
        push_exp("start_beats_step", 24, 13, 2, 22, 13, 32'h7, 3, R, 1, 0, 0, 0);

        op(0, 0, 0, R, 1);
        push_exp("grow_pulse_only", 24, 13, 2, 22, 13, 32'h7, 3, R, 1, 0, 0, 0);
        op(0, 1, 1, R, 0);
        push_exp("grow_held_pause", 24, 13, 2, 22, 13, 32'h7, 3, R, 1, 0, 0, 0);
        op(0, 1, 0, R, 0);
        push_exp("grow_step", 25, 13, 3, 22, 13, 32'hF, 4, R, 1, 0, 0, 1);

        for (int i = 0; i < 19; i++) op(0, 1, 0, R, 1);
        for (int i = 0; i < 8; i++)  op(0, 1, 0, D, 1);
        for (int i = 0; i < 4; i++)  op(0, 1, 0, L, 1);
        push_exp("grow_cap", 40, 21, 31, 25, 13, 32'hFFFF_FFFF, 32, L, 1, 0, 0, 1);

        op(1, 0, 0, R, 0);
        for (int i = 0; i < 23; i++) op(0, 1, 0, R, 0);
        push_exp("at_edge", 47, 13, 2, 45, 13, 32'h7, 3, R, 1, 0, 0, 1);
        op(0, 1, 0, R, 0);
`ifdef WRAP_EN
        push_exp("wrap", 1, 13, 1, 47, 13, 32'h7, 3, R, 1, 0, 0, 1);
`else
        push_exp("wall_hit", 47, 13, 2, 45, 13, 32'h7, 3, R, 0, 1, 0, 0);
        op(0, 1, 0, R, 0);
        push_exp("dead_step", 47, 13, 2, 45, 13, 32'h7, 3, R, 0, 1, 0, 0);
`endif

        op(1, 0, 0, R, 0);
        op(0, 1, 0, R, 1);
        op(0, 1, 0, R, 1);
        op(0, 1, 0, U, 0);
        op(0, 1, 0, L, 0);
        op(0, 1, 0, D, 0);
        push_exp("self_hit", 25, 12, 3, 25, 13, 32'h1F, 5, L, 0, 0, 1, 0);

        op(1, 0, 0, R, 0);
        push_exp("restart_clears", 24, 13, 2, 22, 13, 32'h7, 3, R, 1, 0, 0, 0);
        op(0, 1, 0, R, 1);
        op(0, 1, 0, U, 0);
        op(0, 1, 0, L, 0);
        op(0, 1, 0, D, 0);
        push_exp("tail_vacates", 24, 13, 3, 25, 13, 32'hF, 4, D, 1, 0, 0, 1);
        op(0, 1, 0, R, 1);
        push_exp("grow_into_tail", 24, 13, 3, 25, 13, 32'hF, 4, D, 0, 0, 1, 0);

        op(1, 0, 0, R, 0);
        @(negedge clock);
        step = 1'b1; dir_req = R;
        #2 reset_n = 1'b0;
        @(posedge clock);
        #1 step = 1'b0;
        push_exp("async_reset", 0, 0, 1, 0, 0, 32'h0, 0, R, 0, 0, 0, 0);
        @(negedge clock);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d snapshots unchecked, expected 0", exp_q.size());
        end
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
